// File: rtl/onchip_mem_stream_reader.sv
// rtl/onchip_mem_stream_reader.sv - command-driven memory read engine feeding a credit-gated skid FIFO and a packet stream
// Optional cmd_abort input enabled by defining MEMRD_ABORT_EN.
module onchip_mem_stream_reader #(
    parameter int DATA_W       = 256,
    parameter int ADDR_W       = 10,
    parameter int LEN_W        = 11,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
`ifdef MEMRD_ABORT_EN
    input  logic                cmd_abort,
`endif
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_clken,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                st_valid,
    input  logic                st_ready,
    output logic [DATA_W-1:0]   st_data,
    output logic                st_sop,
    output logic                st_eop,
    output logic                done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    logic [LEN_W-1:0]        rd_left;
    logic [LEN_W-1:0]        beat_left;
    logic                    first_beat;
    logic                    aborting;
    logic [READ_LATENCY-1:0] rd_vld;
    logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          in_flight;
    logic                    push;
    logic                    pop;
    logic                    abort_now;
    logic                    credit_ok;

`ifdef MEMRD_ABORT_EN
    assign abort_now = cmd_abort && (state != IDLE);
`else
    assign abort_now = 1'b0;
`endif

    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;

    assign st_valid = (fifo_count != '0);
    assign st_data  = fifo_mem[rd_ptr];
    assign st_sop   = st_valid && first_beat;
    assign st_eop   = st_valid && (beat_left == LEN_W'(1));

    assign pop  = st_valid && st_ready;
    assign push = rd_vld[READ_LATENCY-1] && !aborting && !abort_now;

    // Reads already committed (current chipselect plus the latency pipe) reserve FIFO slots.
    always_comb begin
        in_flight = {{CNT_W{1'b0}}, mem_chipselect};
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + {{CNT_W{1'b0}}, rd_vld[i]};
        end
    end

    assign credit_ok = (in_flight + {1'b0, fifo_count} - (CNT_W+1)'(pop))
                       < (CNT_W+1)'(FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cmd_ready      <= 1'b0;
            mem_chipselect <= 1'b0;
            mem_address    <= '0;
            rd_left        <= '0;
            beat_left      <= '0;
            first_beat     <= 1'b0;
            aborting       <= 1'b0;
            rd_vld         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            done           <= 1'b0;
        end else begin
            done   <= 1'b0;
            rd_vld <= (rd_vld << 1) | READ_LATENCY'(mem_chipselect);

            if (abort_now) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            end

            if (pop) begin
                first_beat <= 1'b0;
                beat_left  <= beat_left - LEN_W'(1);
            end

            case (state)
                IDLE: begin
                    cmd_ready      <= 1'b1;
                    mem_chipselect <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state          <= (cmd_len == LEN_W'(1)) ? DRAIN : RUN;
                            cmd_ready      <= 1'b0;
                            mem_chipselect <= 1'b1;
                            mem_address    <= cmd_addr;
                            rd_left        <= cmd_len - LEN_W'(1);
                            beat_left      <= cmd_len;
                            first_beat     <= 1'b1;
                            aborting       <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (abort_now) begin
                        mem_chipselect <= 1'b0;
                        aborting       <= 1'b1;
                        state          <= DRAIN;
                    end else if (credit_ok) begin
                        mem_chipselect <= 1'b1;
                        mem_address    <= mem_address + ADDR_W'(1);
                        rd_left        <= rd_left - LEN_W'(1);
                        if (rd_left == LEN_W'(1)) state <= DRAIN;
                    end else begin
                        mem_chipselect <= 1'b0;
                    end
                end
                DRAIN: begin
                    // cmd_ready stays low here so the next command lands the cycle after done.
                    mem_chipselect <= 1'b0;
                    if (abort_now) begin
                        aborting <= 1'b1;
                    end else if (aborting) begin
                        if (in_flight == '0) begin
                            done     <= 1'b1;
                            aborting <= 1'b0;
                            state    <= IDLE;
                        end
                    end else if (pop && beat_left == LEN_W'(1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule
